mem_port_arbiter: RTL and testbench



---
 rtl/ao486_mem_pkg.sv | 20 ++
 rtl/mem_req_latch.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ao486_mem_pkg.sv
// Types and constants shared by the mem-port arbiter and its per-requester latches.
package ao486_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } mem_arb_state_t;

  localparam logic [3:0]  MEM_BE_ALL       = 4'b1111;
  localparam logic [31:0] MEM_TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_wr;
    logic        pending;
  } req_t;

endpackage

// File: rtl/mem_req_latch.sv
// Captures one requester's pulse into a pending request; tracks busy and sticky overrun.
module mem_req_latch
  import ao486_mem_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_done,
  output req_t        o_req,
  output logic        o_busy,
  output logic        o_overrun
);

  req_t r_req;
  logic r_busy;
  logic r_overrun;
  logic w_pulse;

  assign w_pulse = i_rd | i_wr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_req     <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // A simultaneous rd+wr pulse is taken as a write.
      if (w_pulse && !r_busy) begin
        r_req.addr    <= i_addr;
        r_req.wdata   <= i_wdata;
        r_req.is_wr   <= i_wr;
        r_req.pending <= 1'b1;
        r_busy        <= 1'b1;
      end else if (w_pulse) begin
        r_overrun <= 1'b1;
      end
      if (i_done) begin
        r_req.pending <= 1'b0;
        r_busy        <= 1'b0;
      end
    end
  end

  assign o_req     = r_req;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the Avalon-MM mem port,
// one transaction outstanding, with a read timeout and late-data discard.
module mem_port_arbiter
  import ao486_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [1:0]       rq_rd,
  input  logic [1:0]       rq_wr,
  input  logic [1:0][31:0] rq_addr,
  input  logic [1:0][31:0] rq_wdata,
  output logic [1:0]       rq_busy,
  output logic [31:0]      rq_rdata,
  output logic [1:0]       rq_rvalid,
  output logic [1:0]       rq_err,
  output logic [1:0]       rq_overrun,
  output logic [31:0]      avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  output logic [3:0]       avm_byteenable,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  req_t       w_req [2];
  logic [1:0] w_pend;
  logic [1:0] w_done;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_latch
      mem_req_latch u_latch (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .i_rd      (rq_rd[gi]),
        .i_wr      (rq_wr[gi]),
        .i_addr    (rq_addr[gi]),
        .i_wdata   (rq_wdata[gi]),
        .i_done    (w_done[gi]),
        .o_req     (w_req[gi]),
        .o_busy    (rq_busy[gi]),
        .o_overrun (rq_overrun[gi])
      );
      assign w_pend[gi] = w_req[gi].pending;
    end
  endgenerate

  mem_arb_state_t   r_state, w_state_next;
  logic             r_owner, w_owner_next;
  logic             r_last_grant, w_last_grant_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_stale, w_stale_next;
  logic [31:0]      r_address, w_address_next;
  logic [31:0]      r_writedata, w_writedata_next;
  logic             r_read, w_read_next;
  logic             r_write, w_write_next;
  logic [31:0]      r_rdata, w_rdata_next;
  logic [1:0]       r_rvalid, w_rvalid_next;
  logic [1:0]       r_err, w_err_next;
  logic             w_grant;

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_grant_next = r_last_grant;
    w_cnt_next        = r_cnt;
    w_stale_next      = r_stale;
    w_address_next    = r_address;
    w_writedata_next  = r_writedata;
    w_read_next       = r_read;
    w_write_next      = r_write;
    w_rdata_next      = r_rdata;
    w_rvalid_next     = 2'b00;
    w_err_next        = 2'b00;
    w_done            = 2'b00;
    w_grant           = 1'b0;

    // Data belonging to an aborted read is swallowed before any WAIT_RD match.
    if (r_stale && avm_readdatavalid) begin
      w_stale_next = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_pend != 2'b00) begin
          w_grant           = (w_pend == 2'b11) ? ~r_last_grant : w_pend[1];
          w_owner_next      = w_grant;
          w_last_grant_next = w_grant;
          w_address_next    = w_req[w_grant].addr;
          w_writedata_next  = w_req[w_grant].wdata;
          w_write_next      = w_req[w_grant].is_wr;
          w_read_next       = ~w_req[w_grant].is_wr;
          w_state_next      = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          w_read_next  = 1'b0;
          w_write_next = 1'b0;
          if (r_write) begin
            w_done[r_owner] = 1'b1;
            w_state_next    = IDLE;
          end else begin
            w_cnt_next   = '0;
            w_state_next = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid && !r_stale) begin
          w_rdata_next           = avm_readdata;
          w_rvalid_next[r_owner] = 1'b1;
          w_done[r_owner]        = 1'b1;
          w_state_next           = IDLE;
        end else if (r_cnt == CNT_LIMIT) begin
          w_rdata_next           = MEM_TIMEOUT_DATA;
          w_rvalid_next[r_owner] = 1'b1;
          w_err_next[r_owner]    = 1'b1;
          w_done[r_owner]        = 1'b1;
          w_stale_next           = 1'b1;
          w_state_next           = IDLE;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_stale      <= 1'b0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 2'b00;
      r_err        <= 2'b00;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_grant <= w_last_grant_next;
      r_cnt        <= w_cnt_next;
      r_stale      <= w_stale_next;
      r_address    <= w_address_next;
      r_writedata  <= w_writedata_next;
      r_read       <= w_read_next;
      r_write      <= w_write_next;
      r_rdata      <= w_rdata_next;
      r_rvalid     <= w_rvalid_next;
      r_err        <= w_err_next;
    end
  end

  assign avm_address    = r_address;
  assign avm_writedata  = r_writedata;
  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign avm_byteenable = MEM_BE_ALL;
  assign rq_rdata       = r_rdata;
  assign rq_rvalid      = r_rvalid;
  assign rq_err         = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int T = 16;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic [1:0]       rq_rd, rq_wr;
  logic [1:0][31:0] rq_addr, rq_wdata;
  logic [1:0]       rq_busy, rq_rvalid, rq_err, rq_overrun;
  logic [31:0]      rq_rdata, avm_address, avm_writedata, avm_readdata;
  logic             avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [3:0]       avm_byteenable;

  mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_sys           (clk_sys),
    .reset             (reset),
    .rq_rd             (rq_rd),
    .rq_wr             (rq_wr),
    .rq_addr           (rq_addr),
    .rq_wdata          (rq_wdata),
    .rq_busy           (rq_busy),
    .rq_rdata          (rq_rdata),
    .rq_rvalid         (rq_rvalid),
    .rq_err            (rq_err),
    .rq_overrun        (rq_overrun),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: per-requester job slots plus the single in-flight transaction.
  bit          m_busy [2];
  bit          m_ovr [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd [2];
  bit          m_iswr [2];
  bit          m_last;
  bit          m_active, m_cmd, m_stale;
  int          m_own, m_wait;
  logic [31:0] m_caddr, m_cwd;
  bit          m_cwr;
  logic [31:0] m_rdata;
  logic [1:0]  m_rvalid, m_err;

  logic [31:0] issued [$];
  bit          prev_cmd = 1'b0;

  typedef struct { int at; logic [31:0] d; } sched_t;
  sched_t sched [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int done;
    bit st;
    bit p;
    done = -1;
    m_rvalid = 2'b00;
    m_err    = 2'b00;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_ovr[i] = 0;
      end
      m_last = 1; m_active = 0; m_cmd = 0; m_stale = 0; m_wait = 0;
      m_rdata = '0;
      return;
    end
    st = m_stale;
    if (st && avm_readdatavalid) m_stale = 0;
    if (!m_active) begin
      if (m_busy[0] || m_busy[1]) begin
        m_own    = (m_busy[0] && m_busy[1]) ? (m_last ? 0 : 1) : (m_busy[1] ? 1 : 0);
        m_last   = (m_own == 1);
        m_active = 1;
        m_cmd    = 1;
        m_caddr  = m_addr[m_own];
        m_cwd    = m_wd[m_own];
        m_cwr    = m_iswr[m_own];
      end
    end else if (m_cmd) begin
      if (!avm_waitrequest) begin
        m_cmd = 0;
        if (m_cwr) begin
          done = m_own; m_active = 0;
        end else begin
          m_wait = 0;
        end
      end
    end else if (avm_readdatavalid && !st) begin
      m_rdata = avm_readdata; m_rvalid[m_own] = 1'b1; done = m_own; m_active = 0;
    end else if (m_wait == T) begin
      m_rdata = 32'hFFFF_FFFF; m_rvalid[m_own] = 1'b1; m_err[m_own] = 1'b1;
      done = m_own; m_active = 0; m_stale = 1;
    end else begin
      m_wait++;
    end
    for (int i = 0; i < 2; i++) begin
      p = rq_rd[i] | rq_wr[i];
      if (p && !m_busy[i]) begin
        m_busy[i] = 1; m_addr[i] = rq_addr[i]; m_wd[i] = rq_wdata[i]; m_iswr[i] = rq_wr[i];
      end else if (p) begin
        m_ovr[i] = 1;
      end
      if (done == i) m_busy[i] = 0;
    end
  endtask

  task automatic compare_all();
    check("busy", rq_busy, {m_busy[1], m_busy[0]});
    check("overrun", rq_overrun, {m_ovr[1], m_ovr[0]});
    check("rvalid", rq_rvalid, m_rvalid);
    check("err", rq_err, m_err);
    check("rdata", rq_rdata, m_rdata);
    check("avm_read", avm_read, m_cmd && !m_cwr);
    check("avm_write", avm_write, m_cmd && m_cwr);
    check("byteenable", avm_byteenable, 4'hF);
    if (m_cmd) check("avm_address", avm_address, m_caddr);
    if (m_cmd && m_cwr) check("avm_writedata", avm_writedata, m_cwd);
  endtask

  // Inputs are already set for this cycle; advance the model, clock, then compare.
  task automatic cycle();
    model_step();
    @(posedge clk_sys);
    @(negedge clk_sys);
    cyc++;
    compare_all();
    if ((avm_read || avm_write) && !prev_cmd) issued.push_back(avm_address);
    prev_cmd = avm_read || avm_write;
  endtask

  task automatic pair_writes();
    rq_wr = 2'b11; rq_addr[0] = 32'hA0; rq_addr[1] = 32'hB0;
    cycle();
    rq_wr = 2'b00;
    repeat (8) cycle();
  endtask

  initial begin
    int k;
    int held;
    logic [1:0] r;

    reset = 1'b1; rq_rd = '0; rq_wr = '0; rq_addr = '0; rq_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    @(negedge clk_sys);
    cycle();
    reset = 1'b0;
    check("rst_busy", rq_busy, 0);
    check("rst_cmd", {avm_read, avm_write}, 0);
    check("rst_be", avm_byteenable, 32'hF);
    check("rst_rdata", rq_rdata, 0);

    // Single write
    rq_wr = 2'b01; rq_addr[0] = 32'h0000_1000; rq_wdata[0] = 32'hDEAD_BEEF;
    cycle();
    rq_wr = 2'b00;
    check("wr_busy_n1", rq_busy[0], 1);
    check("wr_idle_n1", avm_write, 0);
    cycle();
    check("wr_cmd_n2", avm_write, 1);
    check("wr_addr_n2", avm_address, 32'h0000_1000);
    check("wr_data_n2", avm_writedata, 32'hDEAD_BEEF);
    cycle();
    check("wr_busy_n3", rq_busy[0], 0);

    // Read with stall on requester 1
    avm_waitrequest = 1'b1; rq_rd = 2'b10; rq_addr[1] = 32'h20;
    cycle();
    rq_rd = 2'b00;
    cycle();
    held = 0;
    for (int i = 0; i < 3; i++) begin
      if (avm_read) held++;
      cycle();
    end
    if (avm_read) held++;
    avm_waitrequest = 1'b0;
    cycle();
    check("rd_held", held, 4);
    check("rd_dropped", avm_read, 0);
    repeat (3) cycle();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1234_5678;
    cycle();
    avm_readdatavalid = 1'b0;
    check("rd_rvalid", rq_rvalid, 2'b10);
    check("rd_rdata", rq_rdata, 32'h1234_5678);
    check("rd_busy", rq_busy, 0);

    // Simultaneous pairs just after reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    issued.delete();
    pair_writes();
    pair_writes();
    rq_wr = 2'b01; rq_addr[0] = 32'hC0;
    cycle();
    rq_wr = 2'b00;
    repeat (5) cycle();
    pair_writes();
    check("pair_count", issued.size(), 7);
    if (issued.size() == 7) begin
      check("pair1_first", issued[0], 32'hA0);
      check("pair1_second", issued[1], 32'hB0);
      check("pair2_first", issued[2], 32'hA0);
      check("pair2_second", issued[3], 32'hB0);
      check("pair3_first", issued[5], 32'hB0);
      check("pair3_second", issued[6], 32'hA0);
    end

    // Timeout on requester 0
    rq_rd = 2'b01; rq_addr[0] = 32'h40;
    cycle();
    rq_rd = 2'b00;
    cycle();
    cycle();
    k = 0;
    while (!rq_err[0] && k < 40) begin
      cycle();
      k++;
    end
    check("to_latency", k, 17);
    check("to_rvalid", rq_rvalid, 2'b01);
    check("to_rdata", rq_rdata, 32'hFFFF_FFFF);

    // Stale data from the aborted read is discarded
    rq_rd = 2'b01; rq_addr[0] = 32'h44;
    cycle();
    rq_rd = 2'b00;
    cycle();
    cycle();
    cycle();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h0000_AAAA;
    cycle();
    avm_readdatavalid = 1'b0;
    check("stale_no_rvalid", rq_rvalid, 0);
    check("stale_busy", rq_busy[0], 1);
    cycle();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h0000_5555;
    cycle();
    avm_readdatavalid = 1'b0;
    check("stale_next_rvalid", rq_rvalid, 2'b01);
    check("stale_next_rdata", rq_rdata, 32'h0000_5555);

    // Overrun, then reset during ISSUE
    avm_waitrequest = 1'b1; rq_wr = 2'b01; rq_addr[0] = 32'h80;
    cycle();
    rq_wr = 2'b00;
    cycle();
    rq_rd = 2'b01;
    cycle();
    rq_rd = 2'b00;
    check("ovr_set", rq_overrun, 2'b01);
    check("ovr_cmd_held", avm_write, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    check("rst_mid_busy", rq_busy, 0);
    check("rst_mid_ovr", rq_overrun, 0);
    check("rst_mid_write", avm_write, 0);
    check("rst_mid_addr", avm_address, 0);
    check("rst_mid_be", avm_byteenable, 32'hF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          r = 2'($urandom_range(1, 3));
          rq_rd[i] = r[0];
          rq_wr[i] = r[1];
        end else begin
          rq_rd[i] = 1'b0;
          rq_wr[i] = 1'b0;
        end
        rq_addr[i]  = $urandom;
        rq_wdata[i] = $urandom;
      end
      avm_waitrequest = ($urandom_range(0, 2) == 0);
      if (avm_read && !avm_waitrequest && !reset)
        sched.push_back('{cyc + (($urandom_range(0, 3) == 0) ? $urandom_range(14, 26) : $urandom_range(1, 6)), $urandom});
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (sched.size() > 0 && sched[0].at <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = sched[0].d;
        void'(sched.pop_front());
      end else if ($urandom_range(0, 99) == 0) begin
        avm_readdatavalid = 1'b1;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
